// File: rtl/adc0832_pkg.sv
// Shared types and constants for the ADC0832 serial responder.
// Holds the frame state encoding and the result selection/subtraction rule.
package adc0832_pkg;

    localparam int ADC_DATA_W   = 8;
    localparam int ADC_MSB_BITS = 8;
    localparam int ADC_LSB_BITS = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD_SGL,
        CMD_ODD,
        MUX,
        MSB,
        LSB,
        TAIL
    } adc_state_e;

    // Differential modes subtract in 9 bits so a negative result can be clamped to zero.
    function automatic logic [ADC_DATA_W-1:0] select_result(
        input logic                  sgl,
        input logic                  odd,
        input logic [ADC_DATA_W-1:0] ch0,
        input logic [ADC_DATA_W-1:0] ch1
    );
        logic [ADC_DATA_W:0] diff;
        if (sgl) begin
            return odd ? ch1 : ch0;
        end
        diff = odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
        return diff[ADC_DATA_W] ? '0 : diff[ADC_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous serial line with registered
// rise/fall pulses derived from the last two synchronizer bits.
module adc_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            rise   <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall   <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc0832_responder.sv
// ADC0832 device emulator: decodes the start/SGL/ODD command from the controller
// and shifts the selected 8-bit result back on DO, MSB-first with optional LSB-first echo.
module adc0832_responder
    import adc0832_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_ECHO    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adc_clk,
    input  logic                  adc_cs_n,
    input  logic                  adc_di,
    output logic                  adc_do,
    output logic                  adc_do_oe,
    input  logic [ADC_DATA_W-1:0] ch0_value,
    input  logic [ADC_DATA_W-1:0] ch1_value,
    output logic                  conv_done,
    output logic                  frame_error,
    output logic                  last_sgl,
    output logic                  last_odd
);

    localparam logic [3:0] MSB_LAST = 4'(ADC_MSB_BITS - 1);
    localparam logic [3:0] LSB_LAST = 4'(ADC_LSB_BITS - 1);

    logic clk_level, clk_rise, clk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic di_s, di_rise, di_fall;
    logic unused_edges;

    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .async_in(adc_clk),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    // Chip select resets to the deselected level so the FSM stays idle out of reset.
    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_in(adc_cs_n),
        .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );

    adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
        .clk(clk), .rst_n(rst_n), .async_in(adc_di),
        .level(di_s), .rise(di_rise), .fall(di_fall)
    );

    assign unused_edges = ^{clk_level, cs_rise, cs_fall, di_rise, di_fall};

    adc_state_e            state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADC_DATA_W-1:0] shreg, shreg_n;
    logic                  cmd_sgl, cmd_sgl_n;
    logic                  cmd_odd, cmd_odd_n;
    logic                  do_n, oe_n, done_n, err_n;
    logic                  last_sgl_n, last_odd_n;
    logic [2:0]            bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            cmd_sgl     <= 1'b0;
            cmd_odd     <= 1'b0;
            adc_do      <= 1'b0;
            adc_do_oe   <= 1'b0;
            conv_done   <= 1'b0;
            frame_error <= 1'b0;
            last_sgl    <= 1'b0;
            last_odd    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            cmd_sgl     <= cmd_sgl_n;
            cmd_odd     <= cmd_odd_n;
            adc_do      <= do_n;
            adc_do_oe   <= oe_n;
            conv_done   <= done_n;
            frame_error <= err_n;
            last_sgl    <= last_sgl_n;
            last_odd    <= last_odd_n;
        end
    end

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        cmd_sgl_n  = cmd_sgl;
        cmd_odd_n  = cmd_odd;
        do_n       = adc_do;
        oe_n       = adc_do_oe;
        done_n     = 1'b0;
        err_n      = 1'b0;
        last_sgl_n = last_sgl;
        last_odd_n = last_odd;
        bit_idx    = '0;

        if (cs_n_s) begin
            state_n = IDLE;
            cnt_n   = '0;
            do_n    = 1'b0;
            oe_n    = 1'b0;
            err_n   = state inside {CMD_ODD, MUX, MSB, LSB};
        end else begin
            case (state)
                IDLE: begin
                    state_n = START;
                    cnt_n   = '0;
                end
                START: if (clk_rise && di_s) begin
                    state_n = CMD_SGL;
                    cnt_n   = '0;
                end
                CMD_SGL: if (clk_rise) begin
                    cmd_sgl_n = di_s;
                    state_n   = CMD_ODD;
                    cnt_n     = '0;
                end
                CMD_ODD: if (clk_rise) begin
                    cmd_odd_n = di_s;
                    shreg_n   = select_result(cmd_sgl, di_s, ch0_value, ch1_value);
                    state_n   = MUX;
                    cnt_n     = '0;
                end
                MUX: if (clk_fall) begin
                    oe_n    = 1'b1;
                    do_n    = 1'b0;
                    state_n = MSB;
                    cnt_n   = '0;
                end
                MSB: if (clk_fall) begin
                    bit_idx = 3'(MSB_LAST - cnt);
                    do_n    = shreg[bit_idx];
                    if (cnt == MSB_LAST) begin
                        cnt_n = '0;
                        if (LSB_ECHO) begin
                            state_n = LSB;
                        end else begin
                            state_n    = TAIL;
                            done_n     = 1'b1;
                            last_sgl_n = cmd_sgl;
                            last_odd_n = cmd_odd;
                        end
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                // B0 was the last MSB-first bit, so the echo starts at B1.
                LSB: if (clk_fall) begin
                    bit_idx = 3'(cnt + 4'd1);
                    do_n    = shreg[bit_idx];
                    if (cnt == LSB_LAST) begin
                        cnt_n      = '0;
                        state_n    = TAIL;
                        done_n     = 1'b1;
                        last_sgl_n = cmd_sgl;
                        last_odd_n = cmd_odd;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                TAIL: if (clk_fall) begin
                    do_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc0832_responder.sv
// Bench for adc0832_responder: acts as the ADC controller (adc_clk = clk/16) and
// checks the DO stream of an echo and a no-echo instance against a word-level model.
module tb_adc0832_responder;

    localparam int SYNC     = 2;
    localparam int HALF_ADC = 8;
    localparam int NS       = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       adc_clk = 1'b0;
    logic       adc_cs_n = 1'b1;
    logic       adc_di = 1'b0;
    logic [7:0] ch0_value = 8'h00;
    logic [7:0] ch1_value = 8'h00;

    logic adc_do_e, adc_do_oe_e, conv_done_e, frame_error_e, last_sgl_e, last_odd_e;
    logic adc_do_n, adc_do_oe_n, conv_done_n, frame_error_n, last_sgl_n, last_odd_n;

    always #5 clk = ~clk;

    adc0832_responder #(.SYNC_STAGES(SYNC), .LSB_ECHO(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk), .adc_cs_n(adc_cs_n), .adc_di(adc_di),
        .adc_do(adc_do_e), .adc_do_oe(adc_do_oe_e), .ch0_value(ch0_value), .ch1_value(ch1_value),
        .conv_done(conv_done_e), .frame_error(frame_error_e),
        .last_sgl(last_sgl_e), .last_odd(last_odd_e)
    );

    adc0832_responder #(.SYNC_STAGES(SYNC), .LSB_ECHO(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk), .adc_cs_n(adc_cs_n), .adc_di(adc_di),
        .adc_do(adc_do_n), .adc_do_oe(adc_do_oe_n), .ch0_value(ch0_value), .ch1_value(ch1_value),
        .conv_done(conv_done_n), .frame_error(frame_error_n),
        .last_sgl(last_sgl_n), .last_odd(last_odd_n)
    );

    int n_vec = 0;
    int n_miss = 0;
    int cnt_done_e = 0, cnt_done_n = 0, cnt_err_e = 0, cnt_err_n = 0, cnt_both = 0;

    always @(negedge clk) begin
        if (conv_done_e) cnt_done_e++;
        if (conv_done_n) cnt_done_n++;
        if (frame_error_e) cnt_err_e++;
        if (frame_error_n) cnt_err_n++;
        if ((conv_done_e && frame_error_e) || (conv_done_n && frame_error_n)) cnt_both++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level model: what the converter should return for a command and two inputs.
    function automatic logic [7:0] model_word(input logic sgl, input logic odd,
                                              input logic [7:0] c0, input logic [7:0] c1);
        int a, b, d;
        a = int'(c0);
        b = int'(c1);
        if (sgl) return odd ? c1 : c0;
        d = odd ? (b - a) : (a - b);
        return (d < 0) ? 8'h00 : 8'(d);
    endfunction

    // Bit k is DO seen on the k-th adc_clk rise after the command: null, B7..B0, B1..B7, zeros.
    function automatic logic [31:0] model_stream(input logic [7:0] w, input bit echo, input int n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) begin
            if (k >= 1 && k <= 8) s[k] = w[8-k];
            else if (echo && k >= 9 && k <= 15) s[k] = w[k-8];
        end
        return s;
    endfunction

    task automatic adc_cycle(input logic di_val, output logic d_e, output logic d_n, output logic o_e);
        adc_clk = 1'b0;
        adc_di  = di_val;
        repeat (HALF_ADC) @(negedge clk);
        d_e = adc_do_e;
        d_n = adc_do_n;
        o_e = adc_do_oe_e & adc_do_oe_n;
        adc_clk = 1'b1;
        repeat (HALF_ADC) @(negedge clk);
    endtask

    task automatic run_frame(input logic sgl, input logic odd, input int lead, input int nsamp,
                             input int late_at, input logic [7:0] late_val,
                             output logic [31:0] s_e, output logic [31:0] s_n, output logic [31:0] oe_s);
        logic d_e, d_n, o;
        s_e = '0;
        s_n = '0;
        oe_s = '0;
        adc_cs_n = 1'b0;
        repeat (HALF_ADC) @(negedge clk);
        for (int i = 0; i < lead; i++) adc_cycle(1'b0, d_e, d_n, o);
        adc_cycle(1'b1, d_e, d_n, o);
        adc_cycle(sgl, d_e, d_n, o);
        adc_cycle(odd, d_e, d_n, o);
        for (int k = 0; k < nsamp; k++) begin
            if (k == late_at) ch0_value = late_val;
            adc_cycle(1'b0, d_e, d_n, o);
            s_e[k]  = d_e;
            s_n[k]  = d_n;
            oe_s[k] = o;
        end
    endtask

    task automatic end_frame();
        adc_cs_n = 1'b1;
        repeat (HALF_ADC) @(negedge clk);
        adc_clk = 1'b0;
        repeat (HALF_ADC) @(negedge clk);
    endtask

    task automatic full_frame_check(input string tag, input logic sgl, input logic odd,
                                    input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] w,
                                    input int lead, input int late_at, input logic [7:0] late_val);
        logic [31:0] s_e, s_n, oe_s;
        int de, dn, ee, en;
        ch0_value = c0;
        ch1_value = c1;
        de = cnt_done_e; dn = cnt_done_n; ee = cnt_err_e; en = cnt_err_n;
        run_frame(sgl, odd, lead, NS, late_at, late_val, s_e, s_n, oe_s);
        check({tag, " do stream echo"}, s_e, model_stream(w, 1'b1, NS));
        check({tag, " do stream no-echo"}, s_n, model_stream(w, 1'b0, NS));
        check({tag, " oe during data"}, oe_s, 32'h0003_FFFF);
        end_frame();
        check({tag, " conv_done count e/n"}, {16'(cnt_done_e - de), 16'(cnt_done_n - dn)}, 32'h0001_0001);
        check({tag, " frame_error count"}, 32'(cnt_err_e - ee + cnt_err_n - en), 32'd0);
        check({tag, " last_sgl/odd"}, {28'd0, last_sgl_e, last_odd_e, last_sgl_n, last_odd_n},
              {28'd0, sgl, odd, sgl, odd});
        check({tag, " idle outputs"}, {28'd0, adc_do_oe_e, adc_do_oe_n, adc_do_e, adc_do_n}, 32'd0);
    endtask

    typedef struct {
        logic       sgl;
        logic       odd;
        logic [7:0] ch0;
        logic [7:0] ch1;
        logic [7:0] word;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] s_e, s_n, oe_s;
        int de, dn, ee, en, lat;
        logic r_sgl, r_odd;
        logic [7:0] r0, r1;

        vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b0, 1'b0, 8'h80, 8'h30, 8'h50};
        vecs[3] = '{1'b0, 1'b1, 8'h80, 8'h30, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'h12, 8'h5A, 8'h5A};
        vecs[5] = '{1'b0, 1'b1, 8'h10, 8'hFF, 8'hEF};
        vecs[6] = '{1'b0, 1'b0, 8'h77, 8'h77, 8'h00};

        repeat (3) @(negedge clk);
        check("reset outputs", {20'd0, adc_do_e, adc_do_oe_e, conv_done_e, frame_error_e, last_sgl_e,
              last_odd_e, adc_do_n, adc_do_oe_n, conv_done_n, frame_error_n, last_sgl_n, last_odd_n}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++)
            full_frame_check($sformatf("vec%0d", i), vecs[i].sgl, vecs[i].odd,
                             vecs[i].ch0, vecs[i].ch1, vecs[i].word, 0, -1, 8'h00);

        // Abort after four MSB bits.
        ch0_value = 8'hC3;
        de = cnt_done_e; dn = cnt_done_n; ee = cnt_err_e; en = cnt_err_n;
        run_frame(1'b1, 1'b0, 0, 5, -1, 8'h00, s_e, s_n, oe_s);
        check("abort partial stream", s_e & 32'h1F, model_stream(8'hC3, 1'b1, 5));
        adc_cs_n = 1'b1;
        lat = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!adc_do_oe_e && !adc_do_oe_n) begin
                lat = i + 1;
                break;
            end
        end
        check("abort oe release in time", 32'(lat >= 1 && lat <= SYNC + 2), 32'd1);
        repeat (HALF_ADC) @(negedge clk);
        adc_clk = 1'b0;
        repeat (HALF_ADC) @(negedge clk);
        check("abort frame_error e/n", {16'(cnt_err_e - ee), 16'(cnt_err_n - en)}, 32'h0001_0001);
        check("abort conv_done", 32'(cnt_done_e - de + cnt_done_n - dn), 32'd0);
        check("abort last_* kept", {30'd0, last_sgl_e, last_odd_e}, {30'd0, 1'b0, 1'b0});
        full_frame_check("post-abort", 1'b1, 1'b0, 8'hC3, 8'h00, 8'hC3, 0, -1, 8'h00);

        // Leading zeros before the start bit, ch0 changed after the snapshot.
        full_frame_check("lead/late", 1'b1, 1'b0, 8'h11, 8'h22, 8'h11, 2, 3, 8'hEE);

        // Asynchronous reset in the middle of a frame after last_* were set.
        full_frame_check("pre-reset", 1'b1, 1'b1, 8'h00, 8'h96, 8'h96, 0, -1, 8'h00);
        run_frame(1'b1, 1'b1, 0, 6, -1, 8'h00, s_e, s_n, oe_s);
        #2 rst_n = 1'b0;
        #1 check("async reset mid-frame", {20'd0, adc_do_e, adc_do_oe_e, conv_done_e, frame_error_e,
              last_sgl_e, last_odd_e, adc_do_n, adc_do_oe_n, conv_done_n, frame_error_n, last_sgl_n,
              last_odd_n}, 32'd0);
        adc_cs_n = 1'b1;
        adc_clk = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF_ADC) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            r_sgl = 1'($urandom_range(0, 1));
            r_odd = 1'($urandom_range(0, 1));
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            full_frame_check($sformatf("rand%0d", i), r_sgl, r_odd, r0, r1,
                             model_word(r_sgl, r_odd, r0, r1), int'($urandom_range(0, 2)), -1, 8'h00);
        end

        check("conv_done with frame_error", 32'(cnt_both), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
